relu_maxpool_2x2: RTL and testbench

Streaming ReLU + 2×2/stride-2 max-pooling stage sitting directly downstream of the 2D convolution engine. It consumes the conv engine's valid-qualified signed 22-bit result stream for one 30×30 feature map and emits a 15×15 pooled map in raster order. It handles framing (start/done) and tolerates arbitrary gaps in the input valid.

---
 rtl/npu_pkg.sv | 16 +
 rtl/signed_max2.sv | 12 +
 rtl/relu_maxpool_2x2.sv | 118 +++++++++++
 tb/tb_relu_maxpool_2x2.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: conv output geometry, sample type and the pooling FSM encoding.
package npu_pkg;

  localparam int CONV_OUT_W   = 22;
  localparam int CONV_OUT_DIM = 30;
  localparam int POOL_OUT_DIM = 15;

  typedef logic signed [CONV_OUT_W-1:0] conv_data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } pool_state_e;

endpackage

// File: rtl/signed_max2.sv
// Combinational signed maximum of two W-bit operands.
module signed_max2 #(
  parameter int W = 22
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  assign y = (a > b) ? a : b;

endmodule

// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU + 2x2/stride-2 max-pool over one conv feature map, raster in, raster out.
// Define MAXPOOL_RELU_EN to clamp negative samples to zero before pooling.
module relu_maxpool_2x2
  import npu_pkg::*;
#(
  parameter int IN_WIDTH  = CONV_OUT_DIM,
  parameter int IN_HEIGHT = CONV_OUT_DIM,
  parameter int DATA_W    = CONV_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_signal,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  output logic signed [DATA_W-1:0] pool_out,
  output logic                     pool_valid,
  output logic                     done_signal
);

  localparam int COL_W = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int BUF_D = (IN_WIDTH / 2 > 0) ? IN_WIDTH / 2 : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

  pool_state_e              state;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] h_hold;
  logic signed [DATA_W-1:0] act;
  logic signed [DATA_W-1:0] h_max;
  logic signed [DATA_W-1:0] v_max;
  logic signed [DATA_W-1:0] buf_rd;
  logic signed [DATA_W-1:0] row_buf [BUF_D];
  logic                     accept;
  logic                     col_end;
  logic                     frame_end;

  assign accept    = (state == ST_RUN) && data_valid;
  assign col_end   = (col == COL_LAST);
  assign frame_end = col_end && (row == ROW_LAST);
  assign buf_rd    = row_buf[col[COL_W-1:1]];

  // NOTE: act is assigned on every path of the always_comb, so no latch is inferred.
  always_comb begin
`ifdef MAXPOOL_RELU_EN
    act = data_in[DATA_W-1] ? '0 : data_in;
`else
    act = data_in;
`endif
  end

  // Horizontal pair: held even-column sample against the current odd-column sample.
  signed_max2 #(.W(DATA_W)) u_hmax (
    .a (h_hold),
    .b (act),
    .y (h_max)
  );

  // Vertical pair: buffered even-row result against the current odd-row result.
  signed_max2 #(.W(DATA_W)) u_vmax (
    .a (buf_rd),
    .b (h_max),
    .y (v_max)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      col         <= '0;
      row         <= '0;
      h_hold      <= '0;
      pool_out    <= '0;
      pool_valid  <= 1'b0;
      done_signal <= 1'b0;
    end else begin
      pool_valid  <= 1'b0;
      done_signal <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          col <= '0;
          row <= '0;
          if (start_signal) state <= ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            if (!col[0]) begin
              h_hold <= act;
            end else if (row[0]) begin
              pool_out   <= v_max;
              pool_valid <= 1'b1;
            end
            // A trailing odd column or row only lands in h_hold/row_buf and is never emitted.
            if (col_end) begin
              col <= '0;
              row <= frame_end ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (frame_end) begin
              state       <= ST_DONE;
              done_signal <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the row buffer is not reset; each entry is written on an even row before its odd-row read.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) row_buf[col[COL_W-1:1]] <= h_max;
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Self-checking bench for relu_maxpool_2x2: frame-level reference model plus directed frames.
// Honours MAXPOOL_RELU_EN the same way as the design.
module tb_relu_maxpool_2x2;

  localparam int W  = 30;
  localparam int H  = 30;
  localparam int DW = 22;
  localparam int N_OUT = (W / 2) * (H / 2);
`ifdef MAXPOOL_RELU_EN
  localparam int CONST_EXP = 0;
`else
  localparam int CONST_EXP = -100;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start_signal = 1'b0;
  logic                 data_valid = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic signed [DW-1:0] pool_out;
  logic                 pool_valid;
  logic                 done_signal;

  relu_maxpool_2x2 #(
    .IN_WIDTH  (W),
    .IN_HEIGHT (H),
    .DATA_W    (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_signal (start_signal),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .pool_out     (pool_out),
    .pool_valid   (pool_valid),
    .done_signal  (done_signal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int img [H][W];
  int exp_q [$];
  int exp_last = 0;
  bit drv_complete = 1'b0;
  bit drv_last = 1'b0;
  bit pend_complete = 1'b0;
  bit pend_last = 1'b0;
  int out_cnt = 0;
  int done_cnt = 0;
  int first_out = 0;
  int last_out = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int act_f(input int x);
`ifdef MAXPOOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: every 2x2 window of the activated frame, raster order.
  task automatic build_expect();
    exp_q.delete();
    for (int r = 0; r < H / 2; r++)
      for (int c = 0; c < W / 2; c++)
        exp_q.push_back(max2(max2(act_f(img[2*r][2*c]),   act_f(img[2*r][2*c+1])),
                             max2(act_f(img[2*r+1][2*c]), act_f(img[2*r+1][2*c+1]))));
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = r * W + c;
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample in one cycle; in_frame marks whether the DUT should accept it.
  task automatic send(input int r, input int c, input bit in_frame);
    data_in      = DW'(img[r][c]);
    data_valid   = 1'b1;
    drv_complete = in_frame && (r % 2 == 1) && (c % 2 == 1);
    drv_last     = in_frame && (r == H - 1) && (c == W - 1);
    tick();
    data_valid   = 1'b0;
    drv_complete = 1'b0;
    drv_last     = 1'b0;
  endtask

  task automatic pulse_start();
    start_signal = 1'b1;
    tick();
    start_signal = 1'b0;
  endtask

  task automatic run_frame(input int gap, input int mid_start);
    int done_base;
    out_cnt   = 0;
    done_base = done_cnt;
    build_expect();
    pulse_start();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        repeat (gap) tick();
        if (r * W + c == mid_start) start_signal = 1'b1;
        send(r, c, 1'b1);
        start_signal = 1'b0;
      end
    repeat (3) tick();
    check("out_count", out_cnt, N_OUT);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt - done_base, 1);
  endtask

  // What the DUT accepts on this edge determines the outputs seen half a cycle later.
  always @(posedge clk) begin
    pend_complete = drv_complete && rst;
    pend_last     = drv_last && rst;
  end

  always @(negedge clk) begin
    if (rst) begin
      check("pool_valid", pool_valid, pend_complete);
      check("done_signal", done_signal, pend_last);
      if (pool_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got %0d with no expected output pending", pool_out);
        end else begin
          exp_last = exp_q.pop_front();
          check("pool_out", pool_out, exp_last);
        end
        if (out_cnt == 0) first_out = int'(pool_out);
        last_out = int'(pool_out);
        out_cnt++;
      end else begin
        check("pool_out_hold", pool_out, exp_last);
      end
      if (done_signal) done_cnt++;
    end
  end

  initial begin
    // Reset state
    #1;
    check("rst_pool_valid", pool_valid, 0);
    check("rst_done", done_signal, 0);
    check("rst_pool_out", pool_out, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Ramp, continuous valid
    fill_ramp();
    run_frame(0, -1);
    check("ramp_first", first_out, 31);
    check("ramp_last", last_out, 899);

    // Constant negative frame
    fill_const(-100);
    run_frame(0, -1);
    check("const_first", first_out, CONST_EXP);
    check("const_last", last_out, CONST_EXP);

    // Single window, max from the top row
    fill_const(0);
    img[0][0] = -5; img[0][1] = 3; img[1][0] = -7; img[1][1] = 2;
    run_frame(0, -1);
    check("window_a", first_out, 3);

    // Single window, max from the bottom row
    img[1][1] = 9;
    run_frame(0, -1);
    check("window_b", first_out, 9);

    // Ramp with valid every third cycle
    fill_ramp();
    run_frame(2, -1);
    check("gap_first", first_out, 31);
    check("gap_last", last_out, 899);

    // Reset after 400 accepted samples, then a clean frame
    build_expect();
    pulse_start();
    for (int k = 0; k < 400; k++) send(k / W, k % W, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    exp_last = 0;
    #2;
    check("midrst_pool_valid", pool_valid, 0);
    check("midrst_done", done_signal, 0);
    check("midrst_pool_out", pool_out, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (4) tick();
    run_frame(0, -1);
    check("post_rst_first", first_out, 31);
    check("post_rst_last", last_out, 899);

    // Stray samples in IDLE, start pulsed mid-RUN
    for (int k = 0; k < 10; k++) begin
      data_in    = DW'(1000);
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
    end
    run_frame(0, 137);
    check("stray_first", first_out, 31);
    check("stray_last", last_out, 899);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
